// File: rtl/axi_line_bridge.sv
// Bridges cache line/word requests onto an AXI3 master port.
// Read and write FSMs run independently; a read stalls only when it hits the line held by an active write.
module axi_line_bridge #(
  parameter int          LINE_WORDS = 8,
  parameter logic [3:0]  RD_ID      = 4'h0,
  parameter logic [3:0]  WR_ID      = 4'h1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  // cache read side
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  // cache write side
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [LINE_WORDS*32-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     wr_resp,
  output logic                     resp_err,
  // AXI AR
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  // AXI R
  input  logic [3:0]               rid,
  input  logic [1:0]               rresp,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI AW
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI W
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI B
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int         OFF_BITS  = $clog2(LINE_WORDS * 4);
  localparam int         IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [3:0] LAST_BEAT = 4'(LINE_WORDS - 1);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0]               r_rd_state;
  logic [31:0]              r_rd_addr;
  logic [2:0]               r_rd_type;
  logic [1:0]               r_wr_state;
  logic [31:0]              r_wr_addr;
  logic [2:0]               r_wr_type;
  logic [3:0]               r_wr_strb;
  logic [LINE_WORDS*32-1:0] r_wr_buf;
  logic [3:0]               r_beat;
  logic                     r_wr_resp;
  logic                     r_resp_err;

  logic                     w_rd_accept;
  logic                     w_wr_accept;
  logic                     w_wr_rdy;
  logic                     w_hazard;
  logic                     w_rd_line_req;
  logic                     w_wr_line_req;
  logic [3:0]               w_awlen;
  logic [31:0]              w_words [0:LINE_WORDS-1];
  logic                     w_unused;

  genvar g;
  generate
    for (g = 0; g < LINE_WORDS; g++) begin : g_words
      assign w_words[g] = r_wr_buf[g*32 +: 32];
    end
  endgenerate

  assign w_unused = ^{rid, bid};

  assign w_rd_line_req = (r_rd_type == TYPE_LINE);
  assign w_wr_line_req = (r_wr_type == TYPE_LINE);
  assign w_awlen       = w_wr_line_req ? LAST_BEAT : 4'd0;

  // A same-cycle write to the read's line wins, so it counts as a hazard too.
  assign w_hazard = ((r_wr_state != W_IDLE) &&
                     (rd_addr[31:OFF_BITS] == r_wr_addr[31:OFF_BITS])) ||
                    (w_wr_accept && (rd_addr[31:OFF_BITS] == wr_addr[31:OFF_BITS]));

  assign w_wr_rdy    = !reset && (r_wr_state == W_IDLE) && !flush;
  assign w_wr_accept = wr_req && w_wr_rdy;
  assign wr_rdy      = w_wr_rdy;
  assign rd_rdy      = !reset && (r_rd_state == R_IDLE) && !flush && !w_hazard;
  assign w_rd_accept = rd_req && rd_rdy;

  assign arid    = RD_ID;
  assign araddr  = r_rd_addr;
  assign arlen   = w_rd_line_req ? LAST_BEAT : 4'd0;
  assign arsize  = w_rd_line_req ? 3'b010 : {1'b0, r_rd_type[1:0]};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = !reset && (r_rd_state == R_AR);
  assign rready  = !reset && (r_rd_state == R_DATA);

  assign ret_valid = rvalid && rready;
  assign ret_last  = ret_valid && rlast;
  assign ret_data  = rdata;

  assign awid    = WR_ID;
  assign awaddr  = r_wr_addr;
  assign awlen   = w_awlen;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = !reset && (r_wr_state == W_AW);

  assign wid    = WR_ID;
  assign wvalid = !reset && (r_wr_state == W_DATA);
  assign wdata  = w_words[r_beat[IDX_W-1:0]];
  assign wstrb  = w_wr_line_req ? 4'hF : r_wr_strb;
  assign wlast  = wvalid && (r_beat == w_awlen);
  assign bready = !reset && (r_wr_state == W_RESP);

  assign wr_resp  = r_wr_resp;
  assign resp_err = r_resp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_type  <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_rd_accept) begin
          r_rd_addr  <= rd_addr;
          r_rd_type  <= rd_type;
          r_rd_state <= R_AR;
        end
        R_AR:   if (arvalid && arready) r_rd_state <= R_DATA;
        R_DATA: if (rvalid && rlast) r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_type  <= '0;
      r_wr_strb  <= '0;
      r_wr_buf   <= '0;
      r_beat     <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (w_wr_accept) begin
          r_wr_addr  <= wr_addr;
          r_wr_type  <= wr_type;
          r_wr_strb  <= wr_wstrb;
          r_wr_buf   <= wr_data;
          r_wr_state <= W_AW;
        end
        W_AW: if (awvalid && awready) begin
          r_beat     <= '0;
          r_wr_state <= W_DATA;
        end
        W_DATA: if (wvalid && wready) begin
          r_beat <= r_beat + 4'd1;
          if (wlast) r_wr_state <= W_RESP;
        end
        W_RESP: if (bvalid) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Write-response pulse and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_resp  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      r_wr_resp <= bvalid && bready;
      if ((rvalid && rready && (rresp != 2'b00)) || (bvalid && bready && (bresp != 2'b00)))
        r_resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_line_bridge.sv
// Directed bench for axi_line_bridge: the AXI slave is played by hand, cycle by cycle,
// and every observed output is checked against hand-computed values.
module tb_axi_line_bridge;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0]    rd_type;
  logic [31:0]   rd_addr, ret_data;
  logic          wr_req, wr_rdy, wr_resp, resp_err;
  logic [2:0]    wr_type;
  logic [31:0]   wr_addr;
  logic [3:0]    wr_wstrb;
  logic [LW*32-1:0] wr_data;
  logic [3:0]    arid, arlen, arcache, awid, awlen, awcache, rid, wid, wstrb, bid;
  logic [31:0]   araddr, awaddr, rdata, wdata;
  logic [2:0]    arsize, arprot, awsize, awprot;
  logic [1:0]    arburst, arlock, awburst, awlock, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int vecCount  = 0;
  int missCount = 0;
  int beat;

  always #5 clk = ~clk;

  axi_line_bridge #(.LINE_WORDS(LW), .RD_ID(4'h0), .WR_ID(4'h1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_resp(wr_resp), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance the given number of rising edges, then step 1ns past the last one.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Full single-word write with the slave answering immediately.
  task automatic writeWord(input logic [31:0] addr, input logic [1:0] resp);
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = addr; wr_wstrb = 4'hF;
    applyStimulus(1);
    wr_req = 1'b0; awready = 1'b1;
    applyStimulus(1);
    awready = 1'b0; wready = 1'b1;
    applyStimulus(1);
    wready = 1'b0; bvalid = 1'b1; bresp = resp;
    applyStimulus(1);
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    rd_req = 1'b0; rd_type = 3'b000; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = 4'h0; rresp = 2'b00; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'h1; bresp = 2'b00; bvalid = 1'b0;

    applyStimulus(2); #1;
    checkOutput("reset rd_rdy", rd_rdy, 0);
    checkOutput("reset wr_rdy", wr_rdy, 0);
    checkOutput("reset arvalid", arvalid, 0);
    checkOutput("reset awvalid", awvalid, 0);
    checkOutput("reset wlast", wlast, 0);
    checkOutput("reset resp_err", resp_err, 0);
    applyStimulus(1);
    reset = 1'b0; #1;
    checkOutput("post-reset rd_rdy", rd_rdy, 1);
    checkOutput("post-reset wr_rdy", wr_rdy, 1);

    $display("[TB] line read");
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1FC0_0020;
    applyStimulus(1);
    rd_req = 1'b0; #1;
    checkOutput("lrd arvalid", arvalid, 1);
    checkOutput("lrd araddr", araddr, 32'h1FC0_0020);
    checkOutput("lrd arlen", arlen, 7);
    checkOutput("lrd arsize", arsize, 2);
    checkOutput("lrd arburst", arburst, 1);
    checkOutput("lrd arid", arid, 0);
    checkOutput("lrd rd_rdy busy", rd_rdy, 0);
    applyStimulus(1); #1;
    checkOutput("lrd arvalid held", arvalid, 1);
    checkOutput("lrd araddr held", araddr, 32'h1FC0_0020);
    arready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; #1;
    checkOutput("lrd arvalid dropped", arvalid, 0);
    checkOutput("lrd rready", rready, 1);
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(i); rlast = (i == 7); #1;
      checkOutput("lrd ret_valid", ret_valid, 1);
      checkOutput("lrd ret_data", ret_data, 32'hA000_0000 + 32'(i));
      checkOutput("lrd ret_last", ret_last, (i == 7) ? 32'd1 : 32'd0);
      applyStimulus(1);
    end
    rvalid = 1'b0; rlast = 1'b0; #1;
    checkOutput("lrd rd_rdy after", rd_rdy, 1);
    checkOutput("lrd ret_valid after", ret_valid, 0);

    $display("[TB] byte read");
    rd_req = 1'b1; rd_type = 3'b000; rd_addr = 32'h8000_0003;
    applyStimulus(1);
    rd_req = 1'b0; #1;
    checkOutput("brd araddr", araddr, 32'h8000_0003);
    checkOutput("brd arlen", arlen, 0);
    checkOutput("brd arsize", arsize, 0);
    arready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0000_0055; #1;
    checkOutput("brd ret_valid", ret_valid, 1);
    checkOutput("brd ret_last", ret_last, 1);
    checkOutput("brd ret_data", ret_data, 32'h0000_0055);
    applyStimulus(1);
    rvalid = 1'b0; rlast = 1'b0; #1;
    checkOutput("brd rd_rdy after", rd_rdy, 1);

    $display("[TB] line write, wready toggling");
    for (int i = 0; i < LW; i++) wr_data[i*32 +: 32] = 32'(i);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_3000; wr_wstrb = 4'h0; #1;
    checkOutput("lwr wr_rdy", wr_rdy, 1);
    applyStimulus(1);
    wr_req = 1'b0; #1;
    checkOutput("lwr awvalid", awvalid, 1);
    checkOutput("lwr awaddr", awaddr, 32'h0000_3000);
    checkOutput("lwr awlen", awlen, 7);
    checkOutput("lwr awsize", awsize, 2);
    checkOutput("lwr awburst", awburst, 1);
    checkOutput("lwr awid", awid, 1);
    checkOutput("lwr wr_rdy busy", wr_rdy, 0);
    awready = 1'b1;
    applyStimulus(1);
    awready = 1'b0;
    beat = 0;
    for (int c = 0; c < 16 && beat < 8; c++) begin
      wready = (c % 2 == 0); #1;
      checkOutput("lwr wvalid", wvalid, 1);
      checkOutput("lwr wdata", wdata, 32'(beat));
      checkOutput("lwr wlast", wlast, (beat == 7) ? 32'd1 : 32'd0);
      checkOutput("lwr wstrb", wstrb, 4'hF);
      checkOutput("lwr wid", wid, 1);
      if (wready) beat++;
      applyStimulus(1);
    end
    wready = 1'b0; #1;
    checkOutput("lwr wvalid done", wvalid, 0);
    checkOutput("lwr bready", bready, 1);
    bvalid = 1'b1; #1;
    checkOutput("lwr wr_resp early", wr_resp, 0);
    applyStimulus(1);
    bvalid = 1'b0; #1;
    checkOutput("lwr wr_resp pulse", wr_resp, 1);
    checkOutput("lwr wr_rdy after", wr_rdy, 1);
    applyStimulus(1); #1;
    checkOutput("lwr wr_resp cleared", wr_resp, 0);

    $display("[TB] read/write line hazard");
    wr_data = '0; wr_data[31:0] = 32'hDEAD_BEEF;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_1000; wr_wstrb = 4'h3;
    applyStimulus(1);
    wr_req = 1'b0;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_1004; #1;
    checkOutput("haz rd_rdy same line", rd_rdy, 0);
    applyStimulus(1); #1;
    checkOutput("haz rd_rdy still", rd_rdy, 0);
    checkOutput("haz arvalid idle", arvalid, 0);
    rd_addr = 32'h0000_2000; #1;
    checkOutput("haz rd_rdy other line", rd_rdy, 1);
    applyStimulus(1);
    rd_req = 1'b0; #1;
    checkOutput("haz arvalid concurrent", arvalid, 1);
    checkOutput("haz awvalid concurrent", awvalid, 1);
    checkOutput("haz araddr", araddr, 32'h0000_2000);
    checkOutput("haz awaddr", awaddr, 32'h0000_1000);
    arready = 1'b1; awready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; awready = 1'b0; #1;
    checkOutput("haz wdata", wdata, 32'hDEAD_BEEF);
    checkOutput("haz wstrb", wstrb, 4'h3);
    checkOutput("haz wlast", wlast, 1);
    rvalid = 1'b1; rlast = 1'b1; wready = 1'b1; #1;
    checkOutput("haz ret_last", ret_last, 1);
    applyStimulus(1);
    rvalid = 1'b0; rlast = 1'b0; wready = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h0000_1004; #1;
    checkOutput("haz rd_rdy in W_RESP", rd_rdy, 0);
    bvalid = 1'b1;
    applyStimulus(1);
    bvalid = 1'b0; #1;
    checkOutput("haz rd_rdy cleared", rd_rdy, 1);
    applyStimulus(1);
    rd_req = 1'b0; #1;
    checkOutput("haz late araddr", araddr, 32'h0000_1004);
    arready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    applyStimulus(1);
    rvalid = 1'b0; rlast = 1'b0;

    $display("[TB] same-cycle read and write to one line");
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_4000;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_4008; #1;
    checkOutput("same wr_rdy", wr_rdy, 1);
    checkOutput("same rd_rdy", rd_rdy, 0);
    applyStimulus(1);
    wr_req = 1'b0; #1;
    checkOutput("same awvalid", awvalid, 1);
    checkOutput("same arvalid", arvalid, 0);
    awready = 1'b1;
    applyStimulus(1);
    awready = 1'b0; wready = 1'b1;
    applyStimulus(1);
    wready = 1'b0; bvalid = 1'b1;
    applyStimulus(1);
    bvalid = 1'b0; #1;
    checkOutput("same rd_rdy after write", rd_rdy, 1);
    applyStimulus(1);
    rd_req = 1'b0; #1;
    checkOutput("same arvalid after", arvalid, 1);
    arready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    applyStimulus(1);
    rvalid = 1'b0; rlast = 1'b0;

    $display("[TB] flush during write burst");
    for (int i = 0; i < LW; i++) wr_data[i*32 +: 32] = 32'h10 + 32'(i);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_5000;
    applyStimulus(1);
    wr_req = 1'b0; awready = 1'b1;
    applyStimulus(1);
    awready = 1'b0; wready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      flush = (b == 3); #1;
      checkOutput("flush wdata", wdata, 32'h10 + 32'(b));
      checkOutput("flush wlast", wlast, (b == 7) ? 32'd1 : 32'd0);
      if (b == 3) begin
        checkOutput("flush wvalid held", wvalid, 1);
        checkOutput("flush wr_rdy", wr_rdy, 0);
        checkOutput("flush rd_rdy", rd_rdy, 0);
      end
      applyStimulus(1);
    end
    wready = 1'b0; flush = 1'b1; #1;
    checkOutput("flush bready", bready, 1);
    bvalid = 1'b1;
    applyStimulus(1);
    bvalid = 1'b0; #1;
    checkOutput("flush wr_resp", wr_resp, 1);
    checkOutput("flush wr_rdy idle", wr_rdy, 0);
    flush = 1'b0; #1;
    checkOutput("flush released wr_rdy", wr_rdy, 1);

    $display("[TB] sticky error response");
    writeWord(32'h0000_6000, 2'b10); #1;
    checkOutput("err resp_err set", resp_err, 1);
    writeWord(32'h0000_6040, 2'b00); #1;
    checkOutput("err resp_err sticky", resp_err, 1);

    $display("[TB] reset mid-burst");
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_7000;
    applyStimulus(1);
    rd_req = 1'b0; arready = 1'b1;
    applyStimulus(1);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b0;
    applyStimulus(1);
    reset = 1'b1; #1;
    checkOutput("rst rready", rready, 0);
    checkOutput("rst ret_valid", ret_valid, 0);
    checkOutput("rst rd_rdy", rd_rdy, 0);
    applyStimulus(1);
    reset = 1'b0; rvalid = 1'b0; #1;
    checkOutput("rst resp_err cleared", resp_err, 0);
    checkOutput("rst rd_rdy after", rd_rdy, 1);
    checkOutput("rst arvalid after", arvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
